// File: rtl/bus_arbiter_sched.sv
// Round-robin bus arbiter with split-transaction parking and a windowed utilization meter.
// Define ARB_TIMEOUT_EN to add the hold-timeout watchdog, per-master lockout and timeout_irq.
module bus_arbiter_sched #(
  parameter int NUM_MASTERS = 3,
  parameter int MSEL_W      = 2,
  parameter int TIMEOUT     = 4095,
  parameter int TMO_W       = 12,
  parameter int UTIL_LOG2   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] mreq,
  input  logic                   slave_split,
  input  logic                   slave_ready,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MSEL_W-1:0]      mux_switch,
  output logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] parked,
  output logic                   timeout_irq,
  output logic [7:0]             utilization
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_parked, w_parked_nxt;
  logic [NUM_MASTERS-1:0] r_resume, w_resume_nxt;
  logic [MSEL_W-1:0]      r_msel, w_msel_nxt;
  logic [MSEL_W-1:0]      r_ptr, w_ptr_nxt;

  logic [NUM_MASTERS-1:0] w_lockout;
  logic [NUM_MASTERS-1:0] w_elig;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [MSEL_W-1:0]      w_win_idx;
  logic [MSEL_W:0]        w_rr_idx;
  logic                   w_win_found;
  logic                   w_res_hit;
  logic                   w_exit;

  logic [UTIL_LOG2-1:0]   r_win;
  logic [UTIL_LOG2:0]     r_busy;
  logic [7:0]             r_util;

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0]       r_hold, w_hold_nxt, w_hold_inc;
  logic [NUM_MASTERS-1:0] r_lockout, w_lock_set;
  logic                   r_irq, w_irq_nxt;

  assign w_hold_inc = r_hold + 1'b1;
  assign w_lockout  = r_lockout;
`else
  logic [TMO_W-1:0]       w_unused_tmo;

  assign w_unused_tmo = TMO_W'(TIMEOUT);
  assign w_lockout    = '0;
`endif

  assign w_elig = mreq & ~r_parked & ~w_lockout;

  // A pending resume master pre-empts the round-robin search for one decision.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_win_oh    = '0;
    w_rr_idx    = '0;
    w_res_hit   = |(r_resume & w_elig);
    if (w_res_hit) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!w_win_found && r_resume[i] && w_elig[i]) begin
          w_win_found = 1'b1;
          w_win_idx   = MSEL_W'(i);
          w_win_oh[i] = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        w_rr_idx = {1'b0, r_ptr} + (MSEL_W+1)'(k);
        if (w_rr_idx >= (MSEL_W+1)'(NUM_MASTERS)) begin
          w_rr_idx = w_rr_idx - (MSEL_W+1)'(NUM_MASTERS);
        end
        if (!w_win_found && w_elig[w_rr_idx[MSEL_W-1:0]]) begin
          w_win_found                   = 1'b1;
          w_win_idx                     = w_rr_idx[MSEL_W-1:0];
          w_win_oh[w_rr_idx[MSEL_W-1:0]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_msel_nxt   = r_msel;
    w_ptr_nxt    = r_ptr;
    w_parked_nxt = r_parked;
    w_resume_nxt = r_resume & mreq;
    w_exit       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt   = r_hold;
    w_irq_nxt    = 1'b0;
    w_lock_set   = '0;
`endif

    // Park slot: a parked master giving up its request empties the slot without resume.
    if (|(r_parked & ~mreq)) begin
      w_parked_nxt = '0;
    end else if (slave_ready && (|r_parked)) begin
      w_parked_nxt = '0;
      w_resume_nxt = r_parked;
    end

    case (r_state)
      S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt = '0;
`endif
        if (w_win_found) begin
          w_grant_nxt  = w_win_oh;
          w_msel_nxt   = w_win_idx;
          w_state_nxt  = S_BUSY;
          w_resume_nxt = w_resume_nxt & ~w_win_oh;
        end
      end
      S_BUSY: begin
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt = w_hold_inc;
`endif
        if (!(|(r_grant & mreq))) begin
          w_exit = 1'b1;
        end else if (slave_split && !(|r_parked)) begin
          w_exit       = 1'b1;
          w_parked_nxt = r_grant;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_hold_inc == TMO_W'(TIMEOUT)) begin
          w_exit     = 1'b1;
          w_irq_nxt  = 1'b1;
          w_lock_set = r_grant;
        end
`endif
        if (w_exit) begin
          w_grant_nxt = '0;
          w_state_nxt = S_RELEASE;
          w_ptr_nxt   = (r_msel == MSEL_W'(NUM_MASTERS-1)) ? '0 : r_msel + 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_msel   <= '0;
      r_ptr    <= '0;
      r_parked <= '0;
      r_resume <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_msel   <= w_msel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_parked <= w_parked_nxt;
      r_resume <= w_resume_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_lockout <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_lockout <= (r_lockout & mreq) | w_lock_set;
      r_irq     <= w_irq_nxt;
    end
  end

  assign timeout_irq = r_irq;
`else
  assign timeout_irq = 1'b0;
`endif

  // r_win==0 is the first cycle of a new window; r_busy then holds the full previous window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win  <= '0;
      r_busy <= '0;
      r_util <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (r_win == '0) begin
        r_util <= (r_busy == {1'b1, {UTIL_LOG2{1'b0}}}) ? 8'hFF : r_busy[UTIL_LOG2-1 -: 8];
        r_busy <= {{UTIL_LOG2{1'b0}}, bus_busy};
      end else begin
        r_busy <= r_busy + {{UTIL_LOG2{1'b0}}, bus_busy};
      end
    end
  end

  assign grant       = r_grant;
  assign mux_switch  = r_msel;
  assign bus_busy    = |r_grant;
  assign parked      = r_parked;
  assign utilization = r_util;

endmodule
